// File: rtl/router_scheduler_if.sv
// router_scheduler_if
//   Groups the requester-side and router-side signals of router_scheduler.
//   master : the environment (requesters, downstream readiness, router sink)
//   slave  : the scheduler itself
// Signals
//   req_valid/req_last  [NUM_REQ]            per-requester beat valid / last beat
//   req_addr            [2*NUM_REQ]          destination, slice i = [2i+1:2i]
//   req_data            [DATA_WIDTH*NUM_REQ] beat data, slice i
//   req_ready           [NUM_REQ]            beat accepted this cycle (one-hot or zero)
//   dest_ready          [4]                  router output port k can take a beat
//   rt_din/rt_en/rt_addr                     registered drive into the router
interface router_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [2*NUM_REQ-1:0]          req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [3:0]                    dest_ready;
  logic [DATA_WIDTH-1:0]         rt_din;
  logic                          rt_en;
  logic [1:0]                    rt_addr;

  modport master (
    output req_valid, req_last, req_addr, req_data, dest_ready,
    input  req_ready, rt_din, rt_en, rt_addr
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data, dest_ready,
    output req_ready, rt_din, rt_en, rt_addr
  );
endinterface

// File: rtl/router_scheduler.sv
// router_scheduler
//   Round-robin, per-packet scheduler sharing one simple_router among NUM_REQ
//   requesters. A winner keeps the router until its last beat is accepted.
//   Acceptance is gated on readiness of the destination port; the router
//   inputs are driven from registers (one cycle after acceptance).
// Ports
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   bus      router_scheduler_if.slave (requester handshake + router drive)
//   busy     high while a multi-beat packet holds the router
//   pkt_cnt  four 16-bit completed-packet counters, port k in [16k+15:16k]
// Build option
//   PKT_COUNT_EN  when defined, pkt_cnt counts last beats per destination;
//                 otherwise pkt_cnt is tied to zero and has no flops.
module router_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  router_scheduler_if.slave    bus,
  output logic                 busy,
  output logic [63:0]          pkt_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [1:0]              lock_addr_q, lock_addr_d;
  logic                    rt_en_q, rt_en_d;
  logic [DATA_WIDTH-1:0]   rt_din_q, rt_din_d;
  logic [1:0]              rt_addr_q, rt_addr_d;

  logic [NUM_REQ-1:0]      elig;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    found;
  logic [IDX_W-1:0]        win;
  logic [IDX_W:0]          idx;
  logic [IDX_W-1:0]        sel;
  logic                    accept;
  logic                    acc_last;
  logic [1:0]              acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lock_addr_d = lock_addr_q;
    rt_en_d     = 1'b0;
    rt_din_d    = rt_din_q;
    rt_addr_d   = rt_addr_q;
    req_ready   = '0;
    accept      = 1'b0;
    found       = 1'b0;
    win         = '0;
    idx         = '0;
    acc_last    = 1'b0;
    acc_addr    = lock_addr_q;
    acc_data    = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] && bus.dest_ready[bus.req_addr[2*i +: 2]];
    end

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so that
    // non-power-of-two NUM_REQ never visits an out-of-range index.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      if (!found && elig[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end

    sel = (state_q == LOCK) ? owner_q : win;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel) begin
        acc_data = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
        acc_last = bus.req_last[i];
        // Mid-packet the owner's address is ignored; the locked one is used.
        acc_addr = (state_q == LOCK) ? lock_addr_q : bus.req_addr[2*i +: 2];
      end
    end

    // Grants are masked while reset is asserted so nothing is handed out
    // even though the state flops already hold their reset values.
    if (resetn) begin
      case (state_q)
        ARB: begin
          if (found) begin
            accept         = 1'b1;
            req_ready[win] = 1'b1;
            owner_d        = win;
            lock_addr_d    = acc_addr;
            rr_ptr_d       = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            if (!acc_last) state_d = LOCK;
          end
        end
        LOCK: begin
          if (bus.req_valid[owner_q] && bus.dest_ready[lock_addr_q]) begin
            accept             = 1'b1;
            req_ready[owner_q] = 1'b1;
            if (acc_last) state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end

    if (accept) begin
      rt_en_d   = 1'b1;
      rt_din_d  = acc_data;
      rt_addr_d = acc_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_addr_q <= '0;
      rt_en_q     <= 1'b0;
      rt_din_q    <= '0;
      rt_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_addr_q <= lock_addr_d;
      rt_en_q     <= rt_en_d;
      rt_din_q    <= rt_din_d;
      rt_addr_q   <= rt_addr_d;
    end
  end

`ifdef PKT_COUNT_EN
  logic [3:0][15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (accept && acc_last) pkt_cnt_d[acc_addr] = pkt_cnt_q[acc_addr] + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pkt_cnt_q <= '0;
    else         pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.rt_en     = rt_en_q;
  assign bus.rt_din    = rt_din_q;
  assign bus.rt_addr   = rt_addr_q;
  assign busy          = (state_q == LOCK);

endmodule

// File: doc/router_scheduler.md
Name: router_scheduler

Overview:
Round-robin scheduler that shares one simple_router (din/d_en/addr → dout0..3) between NUM_REQ requesters. Arbitrates per packet: a winner holds the router until its last beat is accepted. Gates acceptance on per-destination downstream readiness and drives the router inputs from registers.

Parameters:
DATA_WIDTH, 32, width of data beats and router din
NUM_REQ, 4, number of requesters (2..8); pointer width IDX_W = $clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester beat is last of packet
req_addr  input  2*NUM_REQ  per-requester destination (slice i = [2i+1:2i])
req_data  input  DATA_WIDTH*NUM_REQ  per-requester beat data (slice i)
req_ready  output  NUM_REQ  beat accepted this cycle (one-hot or zero)
dest_ready  input  4  downstream of router port k can take a beat
rt_din  output  DATA_WIDTH  to router din
rt_en  output  1  to router d_en
rt_addr  output  2  to router addr
busy  output  1  high while in LOCK state
pkt_cnt  output  64  four 16-bit completed-packet counters, port k in [16k+15:16k]

Behaviour:
- Reset (resetn low, async): state=ARB, rr_ptr=0, owner=0, lock_addr=0, rt_en=0, rt_din=0, rt_addr=0, busy=0, pkt_cnt=0, req_ready=0.
- Eligibility in ARB: requester i eligible iff req_valid[i] && dest_ready[req_addr_i].
- ARB: winner = first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. req_ready[winner]=1 combinationally in the same cycle; none eligible → req_ready=0, stay ARB.
- On accept in ARB: owner←winner, lock_addr←req_addr_winner, rr_ptr←(winner+1) mod NUM_REQ. If req_last[winner]=1 → stay ARB (single-beat packet); else → LOCK.
- LOCK: only owner may be served. req_ready[owner]=req_valid[owner] && dest_ready[lock_addr]; all other req_ready=0. Beat routes to lock_addr; owner's req_addr is ignored mid-packet. Accept with req_last=1 → ARB. Owner valid low or dest_ready low → stall in LOCK, no timeout.
- busy=1 exactly while state=LOCK (registered).
- Output register, latency 1: the cycle after any accept, rt_en=1, rt_din=accepted data, rt_addr=effective destination (req_addr in ARB, lock_addr in LOCK). Cycle with no accept → rt_en=0; rt_din and rt_addr hold their previous values.
- req_ready depends combinationally on req_valid and dest_ready; there is no path from outputs back to inputs.
- Back-to-back: new arbitration may accept in the cycle immediately after a last beat; rt_en may stay high continuously.
- Fairness: with all requesters continuously eligible, packet grants rotate 0,1,2,…,NUM_REQ-1,0.
- rr_ptr wraps NUM_REQ-1 → 0; for non-power-of-2 NUM_REQ, use explicit mod compare.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is dropped with no further beats.

Optional Feature:
PKT_COUNT_EN
- Defined: pkt_cnt[16k+15:16k] increments by 1 on every accepted beat with req_last=1 whose effective destination is k. Counters wrap 0xFFFF → 0x0000 and clear only on reset.
- Undefined: pkt_cnt is tied to 0 and no counter flops exist; all other behaviour is identical.

Test Plan:
- Reset: hold resetn=0 with req_valid=4'hF → req_ready=0, rt_en=0, rt_addr=0, rt_din=0; release → first grant goes to requester 0.
- Single beat: req 1 valid, last=1, addr=2, data=32'hBEAD, dest_ready=4'hF → req_ready=4'b0010 in cycle T; at T+1 rt_en=1, rt_addr=2, rt_din=32'hBEAD; busy stays 0.
- Round robin: all 4 requesters valid, single-beat, addr=i, data=32'hA0+i, held 6 cycles → grant order 0,1,2,3,0,1; rt_addr follows 0,1,2,3,0,1 one cycle later.
- Packet lock: req 2 sends a 3-beat packet to addr 3 (data 1,2,3) while req 0 is valid → req 0 blocked for 3 cycles, busy=1 for 2 cycles, rt_addr=3 for all beats, then req 0 granted next.
- Backpressure: in LOCK at addr 1, drop dest_ready[1] for 2 cycles → req_ready=0 and rt_en=0 for those cycles; beat resumes intact afterwards. In ARB, a requester to a not-ready destination is skipped in favour of the next eligible one.
- Reset mid-packet and counters (PKT_COUNT_EN): 2 packets to port 0, then assert resetn low during beat 2 of a third → pkt_cnt[15:0]=2 before reset, all outputs 0 after; preload 0xFFFF packets to port 3 (force) + 1 → wraps to 0.
